tff_count_ctrl: RTL

TFF_COUNT_CTRL -- requirements
Module: tff_count_ctrl

---
 rtl/tff_count_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/tff_count_ctrl.sv
// Sequencer for an external bank of WIDTH T flip-flops: emits per-bit toggle
// enables that walk the bank up or down one step per cycle, and keeps a shadow count.
module tff_count_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode_up,
  input  logic [WIDTH-1:0] limit,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] t_vec,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;

  state_t           state, state_n;
  logic             mode_q, mode_n;
  logic [WIDTH-1:0] lim_q, lim_n;
  logic [WIDTH-1:0] t_n, cnt_n;
  logic             busy_n, done_n;
  logic [WIDTH-1:0] up_tog, dn_tog, init, term;

  // A bit toggles on increment when all lower bits are 1, on decrement when all are 0.
  for (genvar i = 0; i < WIDTH; i++) begin : g_tog
    if (i == 0) begin : g_lsb
      assign up_tog[i] = 1'b1;
      assign dn_tog[i] = 1'b1;
    end else begin : g_upper
      assign up_tog[i] = &count[i-1:0];
      assign dn_tog[i] = ~|count[i-1:0];
    end
  end

  assign init = mode_q ? '0 : lim_q;
  assign term = mode_q ? lim_q : '0;

  always_comb begin
    state_n = state;
    mode_n  = mode_q;
    lim_n   = lim_q;
    t_n     = '0;
    cnt_n   = count;
    busy_n  = busy;
    done_n  = 1'b0;
    if (abort) begin
      state_n = IDLE;
      busy_n  = 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          mode_n  = mode_up;
          lim_n   = limit;
          busy_n  = 1'b1;
          state_n = LOAD;
        end
        // Toggle exactly the bits that differ so the bank lands on init.
        LOAD: begin
          t_n     = count ^ init;
          cnt_n   = init;
          state_n = RUN;
        end
        RUN: begin
          if (pause) begin
            state_n = HOLD;
          end else if (count == term) begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
          end else if (mode_q) begin
            t_n   = up_tog;
            cnt_n = count + 1'b1;
          end else begin
            t_n   = dn_tog;
            cnt_n = count - 1'b1;
          end
        end
        HOLD: if (!pause) state_n = RUN;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mode_q <= 1'b1;
      lim_q  <= '0;
      t_vec  <= '0;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      mode_q <= mode_n;
      lim_q  <= lim_n;
      t_vec  <= t_n;
      count  <= cnt_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

endmodule
